// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the FSM state encoding and small elaboration-time helpers.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam int LOSS_CNT_W  = 8;
    localparam int SYNC_STAGES = 2;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width for values 0..v-1, never below one bit.
    function automatic int width_of(int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with async active-high clear.
// Ports: clk, rst (async, high), d (async input), q (synchronised).
module sync_2ff
    import pll_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: drives PLL reset, qualifies lock, gates system reset,
// retries on lock timeout and flags hard failure when retries run out.
// Ports: refclk, rst (async, high), locked (async), relock_req (pulse);
//   pll_rst, sys_rst, pll_ok, err, retry_cnt, loss_cnt (all registered).
// Build option: define PLL_LOSS_COUNT_EN to count RUN lock-loss events
//   in loss_cnt; otherwise loss_cnt is tied to zero.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter  int PLL_RST_CYCLES     = 16,
    parameter  int LOCK_TIMEOUT       = 100000,
    parameter  int LOCK_STABLE_CYCLES = 1024,
    parameter  int MAX_RETRIES        = 3,
    localparam int RW = width_of(MAX_RETRIES + 1)
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  sys_rst,
    output logic                  pll_ok,
    output logic                  err,
    output logic [RW-1:0]         retry_cnt,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    localparam int CW = width_of(
        max3(LOCK_TIMEOUT, LOCK_STABLE_CYCLES, PLL_RST_CYCLES));

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [RW-1:0] retry_n;
    logic          lock_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    // relock_req wins over every in-state decision.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry_cnt;
        if (relock_req) begin
            state_n = RESET_PLL;
            cnt_n   = '0;
            retry_n = '0;
        end else begin
            unique case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = STABLE;
                        cnt_n   = '0;
                    end else if (cnt == TMO_LAST) begin
                        cnt_n = '0;
                        if (retry_cnt == RTY_MAX) begin
                            state_n = FAIL;
                        end else begin
                            state_n = RESET_PLL;
                            retry_n = retry_cnt + RW'(1);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                STABLE: begin
                    // A lock drop restarts the timeout but costs no retry.
                    if (!lock_s) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_n = RUN;
                        cnt_n   = '0;
                        retry_n = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_n = RESET_PLL;
                        cnt_n   = '0;
                    end
                end
                FAIL: begin
                end
                default: begin
                    state_n = RESET_PLL;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register with it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            pll_ok    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry_cnt <= retry_n;
            pll_rst   <= (state_n == RESET_PLL) || (state_n == FAIL);
            sys_rst   <= (state_n != RUN);
            pll_ok    <= (state_n == RUN);
            err       <= (state_n == FAIL);
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    logic loss_evt;

    // A relock request out of RUN is deliberate, not a loss.
    assign loss_evt = (state == RUN) && !lock_s && !relock_req;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_cnt <= '0;
        end else if (loss_evt && (loss_cnt != '1)) begin
            loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
        end
    end
`else
    assign loss_cnt = '0;
`endif

endmodule
